seq_fetch_decode_wb: RTL and testbench
======================================

# seq_fetch_decode_wb

Combined fetch, decode and write-back front end for the single-cycle (SEQ) Y86-64 processor. It parses an externally supplied 10-byte instruction window at the current PC and produces instruction fields, the constant, and the next sequential PC. It reads operands from a 15-entry register file and commits execute/memory results (valE/valM) into that file on the clock edge. The execute and memory stages live outside this block and feed cnd, valE and valM back in.

## Interface
- No parameters.
- clk  in  1  system clock; register writes occur on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- PC  in  64  address of the current instruction.
- instruct  in  80 (bits [0:79])  instruction bytes PC..PC+9; byte at PC occupies bits [0:7] (MSB side).
- cnd  in  1  condition result from execute (used by cmovXX).
- valE  in  64  ALU result to write back.
- valM  in  64  memory read data to write back.
- icode, ifun  out  4 each  byte0[7:4], byte0[3:0].
- ra, rb  out  4 each  register specifiers; 4'hF when the instruction has no register byte.
- valC  out  64  constant word; 0 when absent.
- valP  out  64  PC of the next sequential instruction.
- mem_err  out  1  instruction address out of range.
- instruct_err  out  1  invalid icode.
- valA, valB  out  64  register operands.
- regis0 … regis14  out  64 each  live register-file contents (%rax … %r14; regis4 = %rsp).

## Operation
- Fetch (combinational):
  - need_regids for icode 2,3,4,5,6,A,B. When set, ra = byte1[7:4] and rb = byte1[3:0].
  - need_valC for icode 3,4,5: valC = bytes 2..9. For icode 7,8: valC = bytes 1..8.
  - Multi-byte valC is big-endian: the lowest-address byte is the most significant.
  - valP = PC + 1 + need_regids + 8·need_valC, computed modulo 2^64.
  - instruct_err = (icode > 4'hB). ifun is passed through unchecked.
  - mem_err = (PC > 1023).
  - Fields are still decoded when either error flag is set.
- Decode (combinational):
  - srcA = ra for icode 2,4,6,A; 4 (%rsp) for icode 9,B; otherwise none.
  - srcB = rb for icode 4,5,6; 4 for icode 8,9,A,B; otherwise none.
  - valA/valB = regs[src]; 0 when the source is none or 4'hF.
- Write-back:
  - dstE = rb for icode 3,6; rb for icode 2 only if cnd = 1; 4 for icode 8,9,A,B; otherwise none.
  - dstM = ra for icode 5,B; otherwise none.
  - On the rising edge with rst = 0, write regs[dstE] ← valE and regs[dstM] ← valM.
  - If dstE == dstM, valM wins.
  - Register 4'hF is never written.
  - No writes while instruct_err or mem_err is asserted.
- Reset: at a rising edge with rst = 1, all 15 registers are cleared to 0 and no write-back occurs.

## Timing
- Fetch and decode outputs are purely combinational in PC, instruct and the register state; they settle the same cycle.
- Write-back latency is one edge: a result is visible on regis*/valA/valB immediately after the rising edge that commits it.
- A read and a write of the same register in one cycle returns the old value until the edge. There is no bypass.
- Reset is sampled only at the rising edge. Between power-up and the first reset edge, register contents are undefined.

## Test plan
- rst = 1 for one edge → all regis0..14 = 0, valA = valB = 0.
- irmovq bytes 35 53 00..00 06 at PC = 66, valE = 6:
  - before the edge: icode = 3, ra = 5, rb = 3, valC = 6, valP = 76;
  - after the edge: regis3 = 6.
- rrmovq 20 03 at PC = 2 with regis0 = 0, valE = 0:
  - cnd = 1 → regis3 becomes 0, valP = 4;
  - repeat with cnd = 0 → regis3 unchanged.
- rmmovq 40 03 00..00 0F at PC = 4 → valA = regis0, valB = regis3, valC = 15, valP = 14, no register write.
- popq B0 4F with valE = 0x108, valM = 0x55 → dstE = dstM = 4, regis4 = 0x55 after the edge (M priority).
- halt at PC = 0 → icode = 0, ra = rb = F, valP = 1.
- Invalid icode C0 → instruct_err = 1, no write.
- PC = 2000 → mem_err = 1, no write.

Source files
------------

// File: rtl/seq_fetch_decode_wb_if.sv
// Bus between the SEQ front end and its environment: instruction window in,
// decoded fields and register operands out, execute/memory results fed back.
interface seq_fetch_decode_wb_if;
  logic [63:0] PC;
  logic [0:79] instruct;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;

  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        mem_err;
  logic        instruct_err;
  logic [63:0] valA;
  logic [63:0] valB;

  logic [63:0] regis0;
  logic [63:0] regis1;
  logic [63:0] regis2;
  logic [63:0] regis3;
  logic [63:0] regis4;
  logic [63:0] regis5;
  logic [63:0] regis6;
  logic [63:0] regis7;
  logic [63:0] regis8;
  logic [63:0] regis9;
  logic [63:0] regis10;
  logic [63:0] regis11;
  logic [63:0] regis12;
  logic [63:0] regis13;
  logic [63:0] regis14;

  // Environment side: supplies PC, instruction bytes and execute/memory results.
  modport master (
    output PC, instruct, cnd, valE, valM,
    input  icode, ifun, ra, rb, valC, valP, mem_err, instruct_err, valA, valB,
    input  regis0, regis1, regis2, regis3, regis4, regis5, regis6, regis7,
    input  regis8, regis9, regis10, regis11, regis12, regis13, regis14
  );

  modport slave (
    input  PC, instruct, cnd, valE, valM,
    output icode, ifun, ra, rb, valC, valP, mem_err, instruct_err, valA, valB,
    output regis0, regis1, regis2, regis3, regis4, regis5, regis6, regis7,
    output regis8, regis9, regis10, regis11, regis12, regis13, regis14
  );
endinterface

// File: rtl/seq_fetch_decode_wb.sv
// Y86-64 SEQ fetch/decode/write-back: combinational instruction parse and
// register read, 15-entry register file committed on the rising clock edge.
module seq_fetch_decode_wb (
  input  logic                  clk,
  input  logic                  rst,
  seq_fetch_decode_wb_if.slave  bus
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [63:0] IMEM_LAST = 64'd1023;

  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic [3:0]  icode;
  logic        need_regids;
  logic        need_valC;
  logic [63:0] valC;

  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic        wb_en;

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];

  // ---------------------------------------------------------------- fetch
  assign byte0 = bus.instruct[0:7];
  assign byte1 = bus.instruct[8:15];
  assign icode = byte0[7:4];

  always_comb begin
    need_regids = 1'b0;
    need_valC   = 1'b0;
    valC        = '0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
        valC        = bus.instruct[16:79];
      end
      // Jumps and call carry the target right after the opcode byte.
      I_JXX, I_CALL: begin
        need_valC = 1'b1;
        valC      = bus.instruct[8:71];
      end
      default: ;
    endcase
  end

  assign bus.icode        = icode;
  assign bus.ifun         = byte0[3:0];
  assign bus.ra           = need_regids ? byte1[7:4] : R_NONE;
  assign bus.rb           = need_regids ? byte1[3:0] : R_NONE;
  assign bus.valC         = valC;
  assign bus.valP         = bus.PC + 64'd1 + {63'd0, need_regids}
                          + (need_valC ? 64'd8 : 64'd0);
  assign bus.instruct_err = (icode > I_POPQ);
  assign bus.mem_err      = (bus.PC > IMEM_LAST);

  // --------------------------------------------------------------- decode
  always_comb begin
    srcA = R_NONE;
    srcB = R_NONE;
    case (icode)
      I_RRMOVQ:           srcA = bus.ra;
      I_RMMOVQ, I_OPQ: begin
        srcA = bus.ra;
        srcB = bus.rb;
      end
      I_MRMOVQ:           srcB = bus.rb;
      I_CALL:             srcB = R_RSP;
      I_RET: begin
        srcA = R_RSP;
        srcB = R_RSP;
      end
      I_PUSHQ: begin
        srcA = bus.ra;
        srcB = R_RSP;
      end
      I_POPQ: begin
        srcA = R_RSP;
        srcB = R_RSP;
      end
      default: ;
    endcase
  end

  assign bus.valA = (srcA == R_NONE) ? 64'd0 : regs_q[srcA];
  assign bus.valB = (srcB == R_NONE) ? 64'd0 : regs_q[srcB];

  // ----------------------------------------------------------- write-back
  always_comb begin
    dstE = R_NONE;
    dstM = R_NONE;
    case (icode)
      I_RRMOVQ:               dstE = bus.cnd ? bus.rb : R_NONE;
      I_IRMOVQ, I_OPQ:        dstE = bus.rb;
      I_MRMOVQ:               dstM = bus.ra;
      I_CALL, I_RET, I_PUSHQ: dstE = R_RSP;
      I_POPQ: begin
        dstE = R_RSP;
        dstM = bus.ra;
      end
      default: ;
    endcase
  end

  assign wb_en = !bus.instruct_err && !bus.mem_err;

  // The M port is applied last so it overrides E when both target one register.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      if (dstE != R_NONE) regs_d[dstE] = bus.valE;
      if (dstM != R_NONE) regs_d[dstM] = bus.valM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.regis0  = regs_q[0];
  assign bus.regis1  = regs_q[1];
  assign bus.regis2  = regs_q[2];
  assign bus.regis3  = regs_q[3];
  assign bus.regis4  = regs_q[4];
  assign bus.regis5  = regs_q[5];
  assign bus.regis6  = regs_q[6];
  assign bus.regis7  = regs_q[7];
  assign bus.regis8  = regs_q[8];
  assign bus.regis9  = regs_q[9];
  assign bus.regis10 = regs_q[10];
  assign bus.regis11 = regs_q[11];
  assign bus.regis12 = regs_q[12];
  assign bus.regis13 = regs_q[13];
  assign bus.regis14 = regs_q[14];

endmodule

// File: tb/tb_seq_fetch_decode_wb.sv
// Bench for seq_fetch_decode_wb: directed instruction scenarios plus random
// instruction windows checked against a byte-level reference model.
module tb_seq_fetch_decode_wb;

  logic clk;
  logic rst;
  seq_fetch_decode_wb_if bus ();

  seq_fetch_decode_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] m_regs [15];
  logic [63:0] obs_regs [15];

  assign obs_regs[0]  = bus.regis0;
  assign obs_regs[1]  = bus.regis1;
  assign obs_regs[2]  = bus.regis2;
  assign obs_regs[3]  = bus.regis3;
  assign obs_regs[4]  = bus.regis4;
  assign obs_regs[5]  = bus.regis5;
  assign obs_regs[6]  = bus.regis6;
  assign obs_regs[7]  = bus.regis7;
  assign obs_regs[8]  = bus.regis8;
  assign obs_regs[9]  = bus.regis9;
  assign obs_regs[10] = bus.regis10;
  assign obs_regs[11] = bus.regis11;
  assign obs_regs[12] = bus.regis12;
  assign obs_regs[13] = bus.regis13;
  assign obs_regs[14] = bus.regis14;

  // ------------------------------------------------------ clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------- drivers
  task automatic drive(input logic [63:0] pc, input logic [0:79] ins,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    bus.PC       = pc;
    bus.instruct = ins;
    bus.cnd      = c;
    bus.valE     = e;
    bus.valM     = m;
    #2;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    drive(64'd0, 80'h6012_0000_0000_0000_0000, 1'b1, 64'hAAAA, 64'hBBBB);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    drive(64'd0, 80'hB044_0000_0000_0000_0000, 1'b0, 64'd0, 64'd0);
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (obs_regs[i] !== 64'd0) $display("FAIL reset_regis%0d got %h want 0", i, obs_regs[i]);
      else n_pass++;
    end
    n_checks++;
    if ({bus.valA, bus.valB} !== 128'd0)
      $display("FAIL reset_valAB got %h/%h want 0/0", bus.valA, bus.valB);
    else n_pass++;
  endtask

  task automatic test_irmovq();
    drive(64'd66, 80'h3553_0000_0000_0000_0006, 1'b0, 64'd6, 64'h99);
    n_checks++;
    if ({bus.icode, bus.ra, bus.rb} !== 12'h353)
      $display("FAIL irmovq_fields got %h%h%h want 353", bus.icode, bus.ra, bus.rb);
    else n_pass++;
    n_checks++;
    if (bus.valC !== 64'd6) $display("FAIL irmovq_valC got %0d want 6", bus.valC);
    else n_pass++;
    n_checks++;
    if (bus.valP !== 64'd76) $display("FAIL irmovq_valP got %0d want 76", bus.valP);
    else n_pass++;
    tick();
    m_regs[3] = 64'd6;
    n_checks++;
    if (bus.regis3 !== 64'd6) $display("FAIL irmovq_wb got %h want 6", bus.regis3);
    else n_pass++;
  endtask

  task automatic test_rrmovq();
    drive(64'd2, 80'h2003_0000_0000_0000_0000, 1'b0, 64'h77, 64'h88);
    n_checks++;
    if (bus.valP !== 64'd4) $display("FAIL rrmovq_valP got %0d want 4", bus.valP);
    else n_pass++;
    n_checks++;
    if (bus.valA !== m_regs[0]) $display("FAIL rrmovq_valA got %h want %h", bus.valA, m_regs[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.regis3 !== m_regs[3]) $display("FAIL rrmovq_cnd0 got %h want %h", bus.regis3, m_regs[3]);
    else n_pass++;
    drive(64'd2, 80'h2003_0000_0000_0000_0000, 1'b1, 64'd0, 64'h88);
    tick();
    m_regs[3] = 64'd0;
    n_checks++;
    if (bus.regis3 !== 64'd0) $display("FAIL rrmovq_cnd1 got %h want 0", bus.regis3);
    else n_pass++;
  endtask

  task automatic test_rmmovq();
    drive(64'd4, 80'h4003_0000_0000_0000_000F, 1'b1, 64'h1234, 64'h5678);
    n_checks++;
    if (bus.valA !== m_regs[0] || bus.valB !== m_regs[3])
      $display("FAIL rmmovq_valAB got %h/%h want %h/%h", bus.valA, bus.valB, m_regs[0], m_regs[3]);
    else n_pass++;
    n_checks++;
    if (bus.valC !== 64'd15 || bus.valP !== 64'd14)
      $display("FAIL rmmovq_valCP got %0d/%0d want 15/14", bus.valC, bus.valP);
    else n_pass++;
    tick();
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (obs_regs[i] !== m_regs[i]) $display("FAIL rmmovq_nowrite r%0d got %h want %h", i, obs_regs[i], m_regs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_popq();
    drive(64'd20, 80'hB04F_0000_0000_0000_0000, 1'b0, 64'h108, 64'h55);
    n_checks++;
    if (bus.valA !== m_regs[4] || bus.valB !== m_regs[4])
      $display("FAIL popq_valAB got %h/%h want %h", bus.valA, bus.valB, m_regs[4]);
    else n_pass++;
    n_checks++;
    if (bus.valP !== 64'd22) $display("FAIL popq_valP got %0d want 22", bus.valP);
    else n_pass++;
    tick();
    m_regs[4] = 64'h55;
    n_checks++;
    if (bus.regis4 !== 64'h55) $display("FAIL popq_mprio got %h want 55", bus.regis4);
    else n_pass++;
  endtask

  task automatic test_halt();
    drive(64'd0, 80'h0000_0000_0000_0000_0000, 1'b1, 64'h1, 64'h2);
    n_checks++;
    if ({bus.icode, bus.ra, bus.rb} !== 12'h0FF || bus.valP !== 64'd1 || bus.valC !== 64'd0)
      $display("FAIL halt got %h%h%h valP=%0d valC=%0d want 0FF valP=1 valC=0",
               bus.icode, bus.ra, bus.rb, bus.valP, bus.valC);
    else n_pass++;
    tick();
  endtask

  task automatic test_errors();
    drive(64'd8, 80'hC035_0000_0000_0000_0000, 1'b1, 64'hDEAD, 64'hBEEF);
    n_checks++;
    if (bus.instruct_err !== 1'b1 || bus.mem_err !== 1'b0)
      $display("FAIL invalid_flags got ierr=%b merr=%b want 1/0", bus.instruct_err, bus.mem_err);
    else n_pass++;
    tick();
    // Address boundary: 1023 is valid, 1024 is not.
    drive(64'd1023, 80'h3003_0000_0000_0000_0011, 1'b1, 64'h11, 64'h0);
    n_checks++;
    if (bus.mem_err !== 1'b0) $display("FAIL pc1023_merr got %b want 0", bus.mem_err);
    else n_pass++;
    drive(64'd1024, 80'h3003_0000_0000_0000_0011, 1'b1, 64'h11, 64'h0);
    n_checks++;
    if (bus.mem_err !== 1'b1) $display("FAIL pc1024_merr got %b want 1", bus.mem_err);
    else n_pass++;
    drive(64'd2000, 80'h30F3_0000_0000_0000_DEAD, 1'b1, 64'hDEAD, 64'hBEEF);
    n_checks++;
    if (bus.mem_err !== 1'b1 || bus.valC !== 64'hDEAD || bus.rb !== 4'h3)
      $display("FAIL pc2000 got merr=%b valC=%h rb=%h want 1/dead/3", bus.mem_err, bus.valC, bus.rb);
    else n_pass++;
    tick();
    drive(64'hFFFF_FFFF_FFFF_FFFE, 80'h30F3_0000_0000_0000_0001, 1'b1, 64'h5, 64'h6);
    n_checks++;
    if (bus.valP !== 64'd8) $display("FAIL valP_wrap got %h want 8", bus.valP);
    else n_pass++;
    tick();
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (obs_regs[i] !== m_regs[i]) $display("FAIL err_nowrite r%0d got %h want %h", i, obs_regs[i], m_regs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random(input int iters);
    logic [7:0]  b [10];
    logic [0:79] ins;
    logic [63:0] pc, e, m, x_valC, x_valP, x_valA, x_valB;
    logic [3:0]  x_icode, x_ra, x_rb;
    logic        c, has_reg, x_ierr, x_merr;
    int          c_at, sa, sb, de, dm;
    for (int it = 0; it < iters; it++) begin
      for (int k = 0; k < 10; k++) b[k] = 8'($urandom_range(0, 255));
      b[0][7:4] = 4'($urandom_range(0, 13));
      pc = ($urandom_range(0, 9) == 0) ? 64'd1024 + 64'($urandom) : 64'($urandom_range(0, 1023));
      c  = 1'($urandom_range(0, 1));
      e  = {$urandom, $urandom};
      m  = {$urandom, $urandom};
      for (int k = 0; k < 10; k++) ins[8*k +: 8] = b[k];

      x_icode = b[0][7:4];
      has_reg = x_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
      c_at    = (x_icode inside {4'h3, 4'h4, 4'h5}) ? 2 : (x_icode inside {4'h7, 4'h8}) ? 1 : 0;
      x_ra    = has_reg ? b[1][7:4] : 4'hF;
      x_rb    = has_reg ? b[1][3:0] : 4'hF;
      x_valC  = 0;
      if (c_at != 0) for (int k = 0; k < 8; k++) x_valC = (x_valC << 8) | 64'(b[c_at + k]);
      x_valP  = pc + 1 + (has_reg ? 1 : 0) + (c_at != 0 ? 8 : 0);
      x_ierr  = (x_icode > 4'hB);
      x_merr  = (pc > 64'd1023);

      sa = 15;
      if (x_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = x_ra;
      if (x_icode inside {4'h9, 4'hB}) sa = 4;
      sb = 15;
      if (x_icode inside {4'h4, 4'h5, 4'h6}) sb = x_rb;
      if (x_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4;
      x_valA = (sa == 15) ? 64'd0 : m_regs[sa];
      x_valB = (sb == 15) ? 64'd0 : m_regs[sb];

      drive(pc, ins, c, e, m);
      n_checks++;
      if ({bus.icode, bus.ifun, bus.ra, bus.rb} !== {x_icode, b[0][3:0], x_ra, x_rb})
        $display("FAIL rnd%0d_fields got %h%h%h%h want %h%h%h%h", it, bus.icode, bus.ifun,
                 bus.ra, bus.rb, x_icode, b[0][3:0], x_ra, x_rb);
      else n_pass++;
      n_checks++;
      if (bus.valC !== x_valC || bus.valP !== x_valP)
        $display("FAIL rnd%0d_valCP got %h/%h want %h/%h", it, bus.valC, bus.valP, x_valC, x_valP);
      else n_pass++;
      n_checks++;
      if ({bus.instruct_err, bus.mem_err} !== {x_ierr, x_merr})
        $display("FAIL rnd%0d_errs got %b%b want %b%b", it, bus.instruct_err, bus.mem_err, x_ierr, x_merr);
      else n_pass++;
      n_checks++;
      if (bus.valA !== x_valA || bus.valB !== x_valB)
        $display("FAIL rnd%0d_valAB got %h/%h want %h/%h", it, bus.valA, bus.valB, x_valA, x_valB);
      else n_pass++;

      tick();
      de = 15;
      dm = 15;
      if (x_icode inside {4'h3, 4'h6}) de = x_rb;
      if (x_icode == 4'h2 && c) de = x_rb;
      if (x_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4;
      if (x_icode inside {4'h5, 4'hB}) dm = x_ra;
      if (!x_ierr && !x_merr) begin
        if (de != 15) m_regs[de] = e;
        if (dm != 15) m_regs[dm] = m;
      end
      for (int i = 0; i < 15; i++) begin
        n_checks++;
        if (obs_regs[i] !== m_regs[i])
          $display("FAIL rnd%0d_wb r%0d got %h want %h", it, i, obs_regs[i], m_regs[i]);
        else n_pass++;
      end
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst          = 1'b0;
    bus.PC       = '0;
    bus.instruct = '0;
    bus.cnd      = 1'b0;
    bus.valE     = '0;
    bus.valM     = '0;
    #1;
    test_reset();
    test_irmovq();
    test_rrmovq();
    test_rmmovq();
    test_popq();
    test_halt();
    test_errors();
    test_random(300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
